// File: rtl/uart_apb_slave.sv
// -----------------------------------------------------------------------------
// uart_apb_slave
//
// APB3 slave front-end sitting directly in front of the UART register file.
// Runs the APB setup/access handshake, inserts WAIT_CYCLES wait states per
// transfer, decodes and checks the address, and drives the register-file
// strobes. Also produces the TX FIFO push pulse and the RX FIFO pop pulse.
//
// Optional build macro: APB_PSTRB_EN
//   defined   : strb follows the latched pstrb on writes; a write to 0x00 with
//               pstrb[0]=0 updates the register but does not push the TX FIFO.
//   undefined : pstrb is ignored and writes always use strb = 4'hF.
//   Reads always present strb = 4'h0.
//
// Parameters:
//   WAIT_CYCLES  wait states before pready (0..15)
//   ADDR_W       APB address width
//   PDATA_W      APB data width (>= 16); upper bits read as zero
//
// Ports:
//   clk, rst_n              APB clock, asynchronous active-low reset
//   psel, penable, pwrite   APB control
//   paddr, pwdata, pstrb    APB address, write data, byte strobes
//   prdata, pready, pslverr APB response
//   wr_en, rd_en, ready     register-file write/read strobes and ready
//   strb, addr, wdata       latched strobes, address, write data
//   rdata                   register-file read data
//   tx_push, rx_pop         FIFO push/pop pulses
// -----------------------------------------------------------------------------
module uart_apb_slave #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 12,
    parameter int PDATA_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic [PDATA_W-1:0] pwdata,
    input  logic [3:0]         pstrb,
    output logic [PDATA_W-1:0] prdata,
    output logic               pready,
    output logic               pslverr,
    output logic               wr_en,
    output logic               rd_en,
    output logic               ready,
    output logic [3:0]         strb,
    output logic [11:0]        addr,
    output logic [15:0]        wdata,
    input  logic [15:0]        rdata,
    output logic               tx_push,
    output logic               rx_pop
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] REG_TX     = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] REG_RX     = ADDR_W'('h04);
    localparam logic [ADDR_W-1:0] REG_STATUS = ADDR_W'('h08);
    localparam logic [ADDR_W-1:0] REG_LAST   = ADDR_W'('h18);

    state_t             state;
    logic [3:0]         cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        wdata_q;
    logic [3:0]         strb_q;
    logic               write_q;
    logic               tx_push_q;

    logic               setup;
    logic               complete;
    logic               err;
    logic               ok;
    logic [3:0]         wr_strb;

`ifdef APB_PSTRB_EN
    assign wr_strb = pstrb;
    logic unused_pwdata;
    assign unused_pwdata = ^pwdata[PDATA_W-1:16];
`else
    assign wr_strb = 4'hF;
    // pstrb and the upper data bits are intentionally ignored in this build.
    logic unused_inputs;
    assign unused_inputs = ^{pstrb, pwdata[PDATA_W-1:16]};
`endif

    assign setup    = (state == IDLE) && psel && !penable;
    assign pready   = (state == ACCESS) && (cnt == 4'd0);
    assign ready    = pready;
    assign complete = pready && psel && penable;

    // Errors are judged on the latched transfer, not the live bus.
    assign err = (addr_q[1:0] != 2'b00)
               || (addr_q > REG_LAST)
               || (write_q && ((addr_q == REG_RX) || (addr_q == REG_STATUS)));

    assign ok      = complete && !err;
    assign pslverr = complete && err;
    assign wr_en   = ok && write_q;
    assign rd_en   = ok && !write_q;
    assign rx_pop  = rd_en && (addr_q == REG_RX);
    assign prdata  = rd_en ? PDATA_W'(rdata) : '0;
    assign tx_push = tx_push_q;
    assign strb    = strb_q;
    assign wdata   = wdata_q;

    generate
        if (ADDR_W >= 12) begin : g_addr_trunc
            assign addr = addr_q[11:0];
        end else begin : g_addr_ext
            assign addr = {{(12-ADDR_W){1'b0}}, addr_q};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 16'd0;
            strb_q    <= 4'd0;
            write_q   <= 1'b0;
            tx_push_q <= 1'b0;
        end else begin
            // The push lands one cycle after the register write, so the FIFO
            // sees the already-updated transmit data.
            tx_push_q <= ok && write_q && (addr_q == REG_TX) && strb_q[0];

            case (state)
                IDLE: begin
                    if (setup) begin
                        state   <= ACCESS;
                        cnt     <= WAIT_INIT;
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata[15:0];
                        strb_q  <= pwrite ? wr_strb : 4'h0;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Master abandoned the transfer: no strobes are issued.
                        state <= IDLE;
                    end else if (penable) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_slave.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_slave
//
// Three instances of uart_apb_slave (WAIT_CYCLES = 0, 3, 2) share the APB bus
// signals; each has its own psel. A vector table drives transfers, pushing
// the expected response onto a scoreboard queue that is popped when the
// selected instance raises pready. Hand-written sequences cover abort,
// reset mid-transfer and the single-cycle tx_push.
// -----------------------------------------------------------------------------
module tb_uart_apb_slave;

    typedef struct {
        int          dut;
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [15:0] rd;
        logic        err;
        logic [31:0] prdata;
        logic        tx;
        logic        rx;
        logic [3:0]  strb;
    } vec_t;

    typedef struct {
        logic        err;
        logic        wr;
        logic        rd;
        logic [31:0] prdata;
        logic        tx;
        logic        rx;
        logic [3:0]  strb;
        logic [11:0] addr;
        logic [15:0] wdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [15:0] rdata;

    logic [31:0] prdata_v [3];
    logic [3:0]  strb_v   [3];
    logic [11:0] addr_v   [3];
    logic [15:0] wdata_v  [3];
    logic [2:0]  pready_v, pslverr_v, wr_en_v, rd_en_v, ready_v, tx_push_v, rx_pop_v;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_apb_slave #(
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 3 : 2),
            .ADDR_W(12),
            .PDATA_W(32)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .psel   (psel_v[g]),
            .penable(penable),
            .pwrite (pwrite),
            .paddr  (paddr),
            .pwdata (pwdata),
            .pstrb  (pstrb),
            .prdata (prdata_v[g]),
            .pready (pready_v[g]),
            .pslverr(pslverr_v[g]),
            .wr_en  (wr_en_v[g]),
            .rd_en  (rd_en_v[g]),
            .ready  (ready_v[g]),
            .strb   (strb_v[g]),
            .addr   (addr_v[g]),
            .wdata  (wdata_v[g]),
            .rdata  (rdata),
            .tx_push(tx_push_v[g]),
            .rx_pop (rx_pop_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wc_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name, input int k);
        check({name, "_pready"},  32'(pready_v[k]),  0);
        check({name, "_ready"},   32'(ready_v[k]),   0);
        check({name, "_pslverr"}, 32'(pslverr_v[k]), 0);
        check({name, "_wr_en"},   32'(wr_en_v[k]),   0);
        check({name, "_rd_en"},   32'(rd_en_v[k]),   0);
        check({name, "_tx_push"}, 32'(tx_push_v[k]), 0);
        check({name, "_rx_pop"},  32'(rx_pop_v[k]),  0);
        check({name, "_prdata"},  prdata_v[k],       0);
    endtask

    // Called at posedge+#1; returns at posedge+#1 one cycle after completion
    // with the bus idle, so a following call gives a back-to-back setup.
    task automatic xfer(input int k, input logic w, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [15:0] rd, input exp_t e);
        int   n;
        logic done;
        exp_t x;
        psel_v    = 3'b000;
        psel_v[k] = 1'b1;
        penable   = 1'b0;
        pwrite    = w;
        paddr     = a;
        pwdata    = d;
        pstrb     = s;
        rdata     = rd;
        sb_q.push_back(e);
        @(posedge clk);
        #1 penable = 1'b1;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pready_v[k]) begin
                done = 1'b1;
                break;
            end
            check("wait_strobes", 32'({wr_en_v[k], rd_en_v[k], rx_pop_v[k], pslverr_v[k]}), 0);
            n++;
        end
        check("pready_seen", 32'(done), 1);
        x = sb_q.pop_front();
        if (done) begin
            check("wait_count", n,                     wc_of(k));
            check("ready",      32'(ready_v[k]),       1);
            check("pslverr",    32'(pslverr_v[k]),     32'(x.err));
            check("wr_en",      32'(wr_en_v[k]),       32'(x.wr));
            check("rd_en",      32'(rd_en_v[k]),       32'(x.rd));
            check("prdata",     prdata_v[k],           x.prdata);
            check("rx_pop",     32'(rx_pop_v[k]),      32'(x.rx));
            check("strb",       32'(strb_v[k]),        32'(x.strb));
            check("addr",       32'(addr_v[k]),        32'(x.addr));
            check("wdata",      32'(wdata_v[k]),       32'(x.wdata));
            check("tx_push_early", 32'(tx_push_v[k]),  0);
        end
        @(posedge clk);
        #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        check("tx_push", 32'(tx_push_v[k]), 32'(x.tx));
    endtask

    function automatic exp_t exp_of(input vec_t v);
        exp_t e;
        e.err    = v.err;
        e.wr     = v.w && !v.err;
        e.rd     = !v.w && !v.err;
        e.prdata = v.prdata;
        e.tx     = v.tx;
        e.rx     = v.rx;
        e.strb   = v.strb;
        e.addr   = v.a;
        e.wdata  = v.d[15:0];
        return e;
    endfunction

    vec_t vecs[$];
    vec_t v;

    initial begin
`ifdef APB_PSTRB_EN
        localparam logic [3:0] PARTIAL_STRB = 4'b0010;
        localparam logic       PARTIAL_TX   = 1'b0;
`else
        localparam logic [3:0] PARTIAL_STRB = 4'hF;
        localparam logic       PARTIAL_TX   = 1'b1;
`endif
        //            dut w     addr    wdata          pstrb  rdata     err   prdata        tx    rx    strb
        vecs.push_back('{0, 1'b1, 12'h010, 32'h0000_0208, 4'hF, 16'h0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{1, 1'b0, 12'h00C, 32'h0000_0000, 4'hF, 16'h000B, 1'b0, 32'h0000_000B, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{0, 1'b1, 12'h000, 32'h0000_0055, 4'hF, 16'h0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'hF});
        vecs.push_back('{0, 1'b0, 12'h004, 32'h0000_0000, 4'hF, 16'h00A5, 1'b0, 32'h0000_00A5, 1'b0, 1'b1, 4'h0});
        vecs.push_back('{0, 1'b1, 12'h008, 32'h0000_1111, 4'hF, 16'h0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{0, 1'b0, 12'h01C, 32'h0000_0000, 4'hF, 16'h1234, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{0, 1'b0, 12'h002, 32'h0000_0000, 4'hF, 16'h5678, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1, 1'b1, 12'h004, 32'h0000_2222, 4'hF, 16'h0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{2, 1'b0, 12'h018, 32'h0000_0000, 4'hF, 16'hFFFF, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{0, 1'b1, 12'h000, 32'h0000_ABCD, 4'b0010, 16'h0000, 1'b0, 32'h0000_0000, PARTIAL_TX, 1'b0, PARTIAL_STRB});
        vecs.push_back('{0, 1'b1, 12'h014, 32'hDEAD_1234, 4'hF, 16'h0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 4'hF});
        vecs.push_back('{0, 1'b0, 12'h000, 32'h0000_0000, 4'hF, 16'h0042, 1'b0, 32'h0000_0042, 1'b0, 1'b0, 4'h0});
        vecs.push_back('{1, 1'b1, 12'h000, 32'h0000_0031, 4'hF, 16'h0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'hF});
        vecs.push_back('{1, 1'b0, 12'h004, 32'h0000_0000, 4'hF, 16'h0077, 1'b0, 32'h0000_0077, 1'b0, 1'b1, 4'h0});

        rst_n   = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 12'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        rdata   = 16'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_idle_outputs("reset", k);
            check("reset_addr",  32'(addr_v[k]),  0);
            check("reset_wdata", 32'(wdata_v[k]), 0);
            check("reset_strb",  32'(strb_v[k]),  0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven transfers, issued back to back
        foreach (vecs[i]) begin
            v = vecs[i];
            xfer(v.dut, v.w, v.a, v.d, v.s, v.rd, exp_of(v));
        end

        // tx_push lasts exactly one cycle
        v = '{0, 1'b1, 12'h000, 32'h0000_0055, 4'hF, 16'h0000, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF};
        xfer(v.dut, v.w, v.a, v.d, v.s, v.rd, exp_of(v));
        @(posedge clk);
        #1 check("tx_push_single", 32'(tx_push_v[0]), 0);

        // Abort: psel dropped during a wait state on the WAIT_CYCLES=2 instance
        psel_v[2] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 12'h000;
        pwdata    = 32'h0000_0077;
        pstrb     = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        check("abort_wait_pready", 32'(pready_v[2]), 0);
        @(posedge clk);
        #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("abort", 2);
        end

        // Reset asserted during ACCESS
        @(posedge clk);
        #1;
        psel_v[2] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 12'h000;
        pwdata    = 32'h0000_0099;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset", 2);
        check("midreset_addr",  32'(addr_v[2]),  0);
        check("midreset_wdata", 32'(wdata_v[2]), 0);
        check("midreset_strb",  32'(strb_v[2]),  0);
        psel_v  = 3'b000;
        penable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle_outputs("postreset", 2);
        end

        // Normal transfer after reset
        @(posedge clk);
        #1;
        v = '{2, 1'b1, 12'h000, 32'h0000_0033, 4'hF, 16'h0000, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF};
        xfer(v.dut, v.w, v.a, v.d, v.s, v.rd, exp_of(v));

        check("scoreboard_empty", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
